// File: rtl/tff_toggle_arbiter.sv
// tff_toggle_arbiter
//   Bank of WIDTH toggle flip-flops shared by NREQ requesters through a
//   round-robin arbiter. Each edge with en high and any request pending grants
//   one requester, which toggles the q bit selected by its idx field.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset    : asynchronous active-high reset
//   en       : global enable; low freezes q, pointer and tog_cnt
//   req      : per-requester level request, held until granted
//   idx      : flattened target bit indices, requester i at idx[i*IW +: IW]
//   gnt      : registered one-hot grant, single-cycle pulse
//   q        : toggle flip-flop bank state
//   busy     : registered (en & |req)
//   tog_cnt  : saturating count of toggles performed
module tff_toggle_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IW-1:0]   idx,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic [15:0]          tog_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    ARB  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [PW-1:0]   r_last;
  logic [NREQ-1:0] r_gnt;
  logic [WIDTH-1:0] r_q;
  logic            r_busy;
  logic [15:0]     r_cnt;

  logic            w_found;
  logic            w_fire;
  logic [PW-1:0]   w_win;
  logic [IW-1:0]   w_sel;
  logic [WIDTH-1:0] w_tog;
  logic [NREQ-1:0] w_gnt_n;
  int unsigned     w_cand;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int unsigned o = 1; o <= NREQ; o++) begin
      w_cand = (int'(r_last) + o) % NREQ;
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = PW'(w_cand);
      end
    end
    w_fire  = en & w_found;
    w_sel   = idx[int'(w_win)*IW +: IW];
    w_tog   = w_fire ? (WIDTH'(1) << w_sel) : '0;
    w_gnt_n = w_fire ? (NREQ'(1) << w_win) : '0;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: if (w_fire)  w_state_n = ARB;
      ARB:  if (!w_fire) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= PW'(NREQ - 1);
      r_gnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_busy  <= en & (|req);
      if (w_fire) begin
        r_q    <= r_q ^ w_tog;
        r_last <= w_win;
        if (r_cnt != '1) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign gnt     = r_gnt;
  assign q       = r_q;
  assign busy    = r_busy;
  assign tog_cnt = r_cnt;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
module tb_tff_toggle_arbiter;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  req;
  logic [11:0] idx;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        busy;
  logic [15:0] tog_cnt;

  int checks = 0;
  int errors = 0;

  tff_toggle_arbiter #(.NREQ(4), .WIDTH(8), .IW(3)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .idx(idx),
    .gnt(gnt), .q(q), .busy(busy), .tog_cnt(tog_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0; req = 4'b0000; idx = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Reset held from time zero, before any clock edge.
    #1;
    checks++;
    if (q !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0 || tog_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state q=%h gnt=%b busy=%b cnt=%h required 00/0000/0/0000",
               q, gnt, busy, tog_cnt);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [7:0] exp_q [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    do_reset();
    en = 1'b1; req = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (gnt !== exp_g[i] || q !== exp_q[i]) begin
        errors++;
        $display("FAIL rr_grant%0d gnt=%b q=%h required %b %h", i, gnt, q, exp_g[i], exp_q[i]);
      end
      if (i == 3) begin
        checks++;
        if (tog_cnt !== 16'd4 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rr_count cnt=%0d busy=%b required 4 1", tog_cnt, busy);
        end
      end
    end
  endtask

  task automatic test_same_bit();
    do_reset();
    en = 1'b1; req = 4'b0101; idx = {3'd0, 3'd5, 3'd0, 3'd5};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (gnt !== ((i % 2 == 0) ? 4'b0001 : 4'b0100) ||
          q !== ((i % 2 == 0) ? 8'h20 : 8'h00)) begin
        errors++;
        $display("FAIL same_bit%0d gnt=%b q=%h", i, gnt, q);
      end
    end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    en = 1'b1; req = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    step();
    step();
    checks++;
    if (gnt !== 4'b0010 || q !== 8'h03 || tog_cnt !== 16'd2) begin
      errors++;
      $display("FAIL freeze_pre gnt=%b q=%h cnt=%0d required 0010 03 2", gnt, q, tog_cnt);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt !== 4'b0000 || q !== 8'h03 || tog_cnt !== 16'd2 || busy !== 1'b0) begin
        errors++;
        $display("FAIL freeze_hold%0d gnt=%b q=%h cnt=%0d busy=%b", i, gnt, q, tog_cnt, busy);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0100 || q !== 8'h07 || tog_cnt !== 16'd3) begin
      errors++;
      $display("FAIL freeze_resume gnt=%b q=%h cnt=%0d required 0100 07 3", gnt, q, tog_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] seq [6];
    seq = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd1, 3'd1};
    do_reset();
    en = 1'b1; req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      idx = {9'd0, seq[i]};
      step();
    end
    checks++;
    if (q !== 8'hA5 || tog_cnt !== 16'd6 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL areset_pre q=%h cnt=%0d gnt=%b required a5 6 0001", q, tog_cnt, gnt);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || gnt !== 4'b0000 || tog_cnt !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_clear q=%h gnt=%b cnt=%h busy=%b required all zero", q, gnt, tog_cnt, busy);
    end
    step();
    reset = 1'b0;
    req = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    step();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'h01 || tog_cnt !== 16'd1) begin
      errors++;
      $display("FAIL areset_first gnt=%b q=%h cnt=%0d required 0001 01 1", gnt, q, tog_cnt);
    end
  endtask

  task automatic test_idx_ignored();
    do_reset();
    en = 1'b1; req = 4'b0001; idx = {3'd7, 3'd7, 3'd7, 3'd0};
    step();
    checks++;
    if (q !== 8'h01 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL idx_ignored q=%h gnt=%b required 01 0001", q, gnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; req = 4'b0001; idx = '0;
    for (int i = 0; i < 65534; i++) step();
    checks++;
    if (tog_cnt !== 16'hFFFE || q !== 8'h00) begin
      errors++;
      $display("FAIL sat_fffe cnt=%h q=%h required fffe 00", tog_cnt, q);
    end
    step();
    checks++;
    if (tog_cnt !== 16'hFFFF || q !== 8'h01) begin
      errors++;
      $display("FAIL sat_ffff cnt=%h q=%h required ffff 01", tog_cnt, q);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (tog_cnt !== 16'hFFFF || q !== ((i == 0) ? 8'h00 : 8'h01) || gnt !== 4'b0001) begin
        errors++;
        $display("FAIL sat_hold%0d cnt=%h q=%h gnt=%b", i, tog_cnt, q, gnt);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; req = 4'b1000; idx = {3'd7, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt !== 4'b1000 || q !== ((i % 2 == 0) ? 8'h80 : 8'h00) || busy !== 1'b1) begin
        errors++;
        $display("FAIL single%0d gnt=%b q=%h busy=%b", i, gnt, q, busy);
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h80 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drop gnt=%b q=%h busy=%b required 0000 80 0", gnt, q, busy);
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || tog_cnt !== 16'd3) begin
      errors++;
      $display("FAIL single_idle gnt=%b busy=%b cnt=%0d required 0000 0 3", gnt, busy, tog_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; req = 4'b0000; idx = '0;
    test_reset();
    test_round_robin();
    test_same_bit();
    test_enable_freeze();
    test_async_reset();
    test_idx_ignored();
    test_single();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
